// File: rtl/stopwatch_key_conditioner.sv
// stopwatch_key_conditioner
//
// Turns the three raw stopwatch push-buttons into clean, debounced,
// single-cycle command pulses for the stopwatch core, plus a debounced
// pressed level for each key. Every key has its own synchroniser, debounce
// counter and press/release FSM, so bounce on one key cannot disturb another.
//
// Parameters:
//   DEBOUNCE_CYCLES  consecutive stable samples needed to accept a press or
//                    a release (legal range 2 .. 2^CNT_W-1)
//   CNT_W            debounce counter width
//   KEY_ACTIVE_LOW   1: a raw key reads 0 while pressed
//
// Ports:
//   clk            in   system clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   key_rest_raw   in   raw reset button (asynchronous to clk)
//   key_start_raw  in   raw start/stop button (asynchronous to clk)
//   key_read_raw   in   raw read/lap button (asynchronous to clk)
//   rest           out  one-cycle pulse per accepted reset press
//   start          out  one-cycle pulse per accepted start/stop press
//   read           out  one-cycle pulse per accepted read press
//   key_level      out  debounced pressed level {rest, start, read}, 1 = pressed
//
// All outputs come straight from flops; no raw input reaches an output
// combinationally.

module stopwatch_key_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20,
  parameter bit          KEY_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_rest_raw,
  input  logic       key_start_raw,
  input  logic       key_read_raw,
  output logic       rest,
  output logic       start,
  output logic       read,
  output logic [2:0] key_level
);

  typedef enum logic [1:0] {
    StIdle,
    StPressWait,
    StPressed,
    StReleaseWait
  } key_state_e;

  // The sample that moves a key out of IDLE (or PRESSED) is the first of the
  // DEBOUNCE_CYCLES stable samples, so the wait state only has to see
  // DEBOUNCE_CYCLES-1 more; with the counter starting at 0 that is the sample
  // taken while the counter holds DEBOUNCE_CYCLES-2.
  localparam logic [CNT_W-1:0] CntLast = CNT_W'(DEBOUNCE_CYCLES - 2);

  // Level the synchroniser holds while the key is untouched.
  localparam logic RelLevel = KEY_ACTIVE_LOW;

  logic [2:0] key_raw;
  logic [2:0] pulse;
  logic [2:0] level;

  assign key_raw = {key_rest_raw, key_start_raw, key_read_raw};

  for (genvar k = 0; k < 3; k++) begin : g_key
    logic             sync1_q;
    logic             sync2_q;
    logic             pressed;
    key_state_e       state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pulse_q;
    logic             level_q;

    // Two-flop synchroniser; reset to the released level so a key held
    // through reset is seen as a fresh press afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= RelLevel;
        sync2_q <= RelLevel;
      end else begin
        sync1_q <= key_raw[k];
        sync2_q <= sync1_q;
      end
    end

    // Normalise polarity: pressed is active-high regardless of the board.
    assign pressed = sync2_q ^ RelLevel;

    // Press/release FSM with registered pulse and level outputs.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= StIdle;
        cnt_q   <= '0;
        pulse_q <= 1'b0;
        level_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        unique case (state_q)
          StIdle: begin
            if (pressed) begin
              state_q <= StPressWait;
              cnt_q   <= '0;
            end
          end

          StPressWait: begin
            if (!pressed) begin
              // Bounce: drop back and start over on the next press.
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q <= StPressed;
              cnt_q   <= '0;
              pulse_q <= 1'b1;
              level_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          StPressed: begin
            // Holding the key never repeats the pulse.
            if (!pressed) begin
              state_q <= StReleaseWait;
              cnt_q   <= '0;
            end
          end

          StReleaseWait: begin
            if (pressed) begin
              // Release bounce: key is still down, no new pulse.
              state_q <= StPressed;
              cnt_q   <= '0;
            end else if (cnt_q == CntLast) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end

          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end

    assign pulse[k] = pulse_q;
    assign level[k] = level_q;
  end

  assign rest      = pulse[2];
  assign start     = pulse[1];
  assign read      = pulse[0];
  assign key_level = level;

endmodule

// File: tb/tb_stopwatch_key_conditioner.sv
// Directed bench for stopwatch_key_conditioner with DEBOUNCE_CYCLES = 4.
// Raw keys are active-low; vectors are {rest, start, read}. Each vector is
// driven just after a rising edge, and outputs are compared 1 ns after the
// following edge (the edge that captures the vector into the first
// synchroniser flop).

module tb_stopwatch_key_conditioner;

  localparam int unsigned DEB = 4;

  typedef struct {
    logic [2:0] raw;
    logic [2:0] pulse;
    logic [2:0] level;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] raw = 3'b111;
  logic       rest;
  logic       start;
  logic       read;
  logic [2:0] key_level;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[$];

  stopwatch_key_conditioner #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W          (8),
    .KEY_ACTIVE_LOW (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_rest_raw (raw[2]),
    .key_start_raw(raw[1]),
    .key_read_raw (raw[0]),
    .rest         (rest),
    .start        (start),
    .read         (read),
    .key_level    (key_level)
  );

  always #5 clk = ~clk;

  function automatic void add(logic [2:0] r, logic [2:0] p, logic [2:0] l);
    vec_t v;
    v.raw   = r;
    v.pulse = p;
    v.level = l;
    vecs.push_back(v);
  endfunction

  task automatic check_outputs(string tag, int idx, logic [2:0] ep, logic [2:0] el);
    n_checks++;
    if ({rest, start, read} !== ep) begin
      n_fail++;
      $display("FAIL %s[%0d] pulses: got %b expected %b", tag, idx, {rest, start, read}, ep);
    end
    n_checks++;
    if (key_level !== el) begin
      n_fail++;
      $display("FAIL %s[%0d] key_level: got %b expected %b", tag, idx, key_level, el);
    end
  endtask

  task automatic step(string tag, int idx, logic [2:0] r, logic [2:0] ep, logic [2:0] el);
    raw = r;
    @(posedge clk);
    #1;
    check_outputs(tag, idx, ep, el);
  endtask

  initial begin
    // ---------------- vector table ----------------
    add(3'b111, 3'b000, 3'b000);
    // Clean press on start, held 20 cycles, then released.
    for (int k = 0; k < 20; k++)
      add(3'b101, (k == 5) ? 3'b010 : 3'b000, (k >= 5) ? 3'b010 : 3'b000);
    for (int k = 0; k < 8; k++)
      add(3'b111, 3'b000, (k < 5) ? 3'b010 : 3'b000);
    // Bounce on read: 0,1,0,1 then stable 0.
    add(3'b110, 3'b000, 3'b000);
    add(3'b111, 3'b000, 3'b000);
    add(3'b110, 3'b000, 3'b000);
    add(3'b111, 3'b000, 3'b000);
    for (int k = 0; k < 10; k++)
      add(3'b110, (k == 5) ? 3'b001 : 3'b000, (k >= 5) ? 3'b001 : 3'b000);
    for (int k = 0; k < 8; k++)
      add(3'b111, 3'b000, (k < 5) ? 3'b001 : 3'b000);
    // Glitch on rest, 3 cycles: rejected.
    for (int k = 0; k < 3; k++) add(3'b011, 3'b000, 3'b000);
    for (int k = 0; k < 8; k++) add(3'b111, 3'b000, 3'b000);
    // Rest low exactly 4 cycles: the minimum accepted width.
    for (int k = 0; k < 4; k++) add(3'b011, 3'b000, 3'b000);
    for (int k = 4; k < 13; k++)
      add(3'b111, (k == 5) ? 3'b100 : 3'b000, (k >= 5 && k < 9) ? 3'b100 : 3'b000);
    // All three keys together.
    for (int k = 0; k < 10; k++)
      add(3'b000, (k == 5) ? 3'b111 : 3'b000, (k >= 5) ? 3'b111 : 3'b000);
    for (int k = 0; k < 8; k++)
      add(3'b111, 3'b000, (k < 5) ? 3'b111 : 3'b000);

    // ---------------- reset state ----------------
    raw   = 3'b111;
    rst_n = 1'b0;
    #1;
    check_outputs("reset", 0, 3'b000, 3'b000);
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1, 3'b000, 3'b000);
    rst_n = 1'b1;

    // ---------------- table ----------------
    for (int i = 0; i < vecs.size(); i++)
      step("table", i, vecs[i].raw, vecs[i].pulse, vecs[i].level);

    // ---------------- release bounce ----------------
    for (int k = 0; k < 8; k++)
      step("rb_press", k, 3'b101, (k == 5) ? 3'b010 : 3'b000, (k >= 5) ? 3'b010 : 3'b000);
    for (int k = 0; k < 2; k++) step("rb_up", k, 3'b111, 3'b000, 3'b010);
    for (int k = 0; k < 8; k++) step("rb_down", k, 3'b101, 3'b000, 3'b010);
    for (int k = 0; k < 8; k++)
      step("rb_release", k, 3'b111, 3'b000, (k < 5) ? 3'b010 : 3'b000);

    // ---------------- reset mid-operation ----------------
    for (int k = 0; k < 8; k++)
      step("mr_read", k, 3'b110, (k == 5) ? 3'b001 : 3'b000, (k >= 5) ? 3'b001 : 3'b000);
    // Start pressed too; after 5 captures its counter is 2 in PRESS_WAIT.
    for (int k = 0; k < 5; k++) step("mr_start", k, 3'b100, 3'b000, 3'b001);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("mr_async", 0, 3'b000, 3'b000);
    raw = 3'b101;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check_outputs("mr_held", k, 3'b000, 3'b000);
    end
    rst_n = 1'b1;
    for (int k = 0; k < 8; k++)
      step("mr_after", k, 3'b101, (k == 5) ? 3'b010 : 3'b000, (k >= 5) ? 3'b010 : 3'b000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
